dac_spi_tx: RTL and testbench
=============================

Name: dac_spi_tx

Overview:
- Transmit side of the processor's 12-bit `dac_output` path.
- Accepts one 12-bit sample per `clk_4khz_en`-rate strobe and serializes it as a 16-bit SPI-mode-0 frame to an external MCP4921-class DAC.
- Sits between `phi_n_neural_processor` and the board DAC pins.
- Provides a one-entry latest-wins buffer, overrun accounting, and an optional LDAC latch pulse.

Parameters:
- SCLK_HALF, 4: clk cycles per SCLK half-period (SCLK = clk / (2*SCLK_HALF)); legal range 2..255.
- CS_GAP, 4: minimum cycles `dac_cs_n` stays high between frames; legal range 1..255.
- BUF_BIT, 0: frame bit 14 (VREF buffer enable).
- GAIN_N_BIT, 1: frame bit 13 (1 = 1x gain).
- LDAC_WIDTH, 2: `dac_ldac_n` low-pulse length in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock (125 MHz)
- rst  in  1  synchronous active-high reset
- sample_in  in  12  unsigned DAC code
- sample_valid  in  1  one-cycle strobe; `sample_in` is valid on this cycle
- dac_sclk  out  1  SPI clock; idles low
- dac_mosi  out  1  SPI data, MSB first
- dac_cs_n  out  1  chip select, active low
- dac_ldac_n  out  1  DAC latch strobe, active low
- busy  out  1  high whenever FSM is not IDLE
- frame_done  out  1  one-cycle pulse at end of each frame
- overrun_count  out  8  saturating count of dropped samples

Behaviour:
- Reset: the following apply on the next edge, from any state including mid-frame:
  - `dac_sclk`=0, `dac_mosi`=0, `dac_cs_n`=1, `dac_ldac_n`=1, `busy`=0, `frame_done`=0, `overrun_count`=0.
  - Pending buffer is cleared; FSM goes to IDLE.
- Pending buffer:
  - Each cycle with `sample_valid`=1 writes `sample_in` into the pending buffer and sets `pend_full`.
  - If `pend_full` was already 1 and is not being consumed that cycle, the old value is lost and `overrun_count` increments, saturating at 255.
  - Consume and write in the same cycle: the new value is kept, with no overrun.
- Frame word: {1'b0, BUF_BIT, GAIN_N_BIT, 1'b1, data[11:0]}, shifted MSB first.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP, LDAC.
- IDLE:
  - If `pend_full`: load the shift register, clear `pend_full`, drive `dac_cs_n`=0 and `dac_mosi`=bit15, go to SETUP.
  - Latency from `sample_valid` at cycle N: `dac_cs_n` falls at edge N+2.
- SETUP: hold for SCLK_HALF cycles, then go to SHIFT with `dac_sclk` rising.
- SHIFT: 16 bit periods.
  - `dac_sclk` is high for SCLK_HALF cycles, then low for SCLK_HALF cycles.
  - `dac_mosi` advances to the next bit on each falling edge, except after bit0.
  - After the 16th falling edge, go to HOLD.
- HOLD:
  - `dac_cs_n` stays low for SCLK_HALF cycles, then rises.
  - `frame_done` pulses on the cycle `dac_cs_n` rises.
  - Then go to GAP.
- Frame timing: `dac_cs_n` is low for exactly (34*SCLK_HALF) cycles, i.e. 136 at default.
- GAP: hold `dac_cs_n` high for CS_GAP cycles, then go to LDAC (feature enabled) or IDLE.
- LDAC: `dac_ldac_n`=0 for LDAC_WIDTH cycles, then go to IDLE.
- `busy` is 1 in every state except IDLE.
- Samples arriving while busy go only to the pending buffer; frames are never aborted except by `rst`.
- `dac_sclk` is never high while `dac_cs_n`=1.
- All outputs are registered, with no combinational paths from inputs.

Optional Feature:
- Macro: DAC_SPI_TX_LDAC_EN.
- Defined: LDAC state present; `dac_ldac_n` pulses low for LDAC_WIDTH cycles after every GAP, and `frame_done` timing is unchanged.
- Undefined: LDAC state absent; `dac_ldac_n` is tied 0 (DAC updates on `dac_cs_n` rise); GAP goes directly to IDLE.

Test Plan:
- Reset then `sample_in`=12'hA5C with one `sample_valid` pulse → MOSI samples on SCLK rising edges = 16'h3A5C; `dac_cs_n` low 136 cycles; exactly 16 SCLK rises; one `frame_done`; `overrun_count`=0.
- Three strobes 12'h001, 12'h002, 12'h003 spaced 40 cycles, first while IDLE:
  - Frame 1 = 16'h3001, frame 2 = 16'h3003.
  - `overrun_count`=1; exactly 2 `frame_done` pulses.
- Strobes every 31250 cycles (4 kHz) with ramp 0..4095 step 512 → 8 frames, data codes match in order, `busy` low between frames, `overrun_count`=0.
- Assert `rst` for 1 cycle at SHIFT bit 7 → next cycle `dac_cs_n`=1, `dac_sclk`=0, `busy`=0; a following strobe of 12'hFFF yields a clean frame 16'h3FFF.
- 300 back-to-back-overrun strobes → `overrun_count` saturates at 255 and holds.
- With DAC_SPI_TX_LDAC_EN defined: `dac_ldac_n` low exactly 2 cycles, starting CS_GAP cycles after `dac_cs_n` rises. Undefined: `dac_ldac_n` constantly 0.

Source files
------------

// File: rtl/dac_spi_tx.sv
// SPI-mode-0 transmitter for a 12-bit MCP4921-class DAC with a latest-wins sample buffer.
// Define DAC_SPI_TX_LDAC_EN to add an LDAC latch pulse after each frame gap.
module dac_spi_tx #(
   parameter int SCLK_HALF  = 4,
   parameter int CS_GAP     = 4,
   parameter bit BUF_BIT    = 1'b0,
   parameter bit GAIN_N_BIT = 1'b1,
   parameter int LDAC_WIDTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] sample_in,
   input  logic        sample_valid,
   output logic        dac_sclk,
   output logic        dac_mosi,
   output logic        dac_cs_n,
   output logic        dac_ldac_n,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  overrun_count
);

   if (SCLK_HALF < 2 || SCLK_HALF > 255) begin : g_bad_half
      $error("SCLK_HALF out of range");
   end
   if (CS_GAP < 1 || CS_GAP > 255) begin : g_bad_gap
      $error("CS_GAP out of range");
   end
   if (LDAC_WIDTH < 1 || LDAC_WIDTH > 255) begin : g_bad_ldac
      $error("LDAC_WIDTH out of range");
   end

   localparam logic [8:0] HALF_LAST = 9'(SCLK_HALF - 1);
   localparam logic [8:0] BIT_LAST  = 9'(2 * SCLK_HALF - 1);
   localparam logic [8:0] GAP_LAST  = 9'(CS_GAP - 1);

`ifdef DAC_SPI_TX_LDAC_EN
   localparam logic [8:0] LDAC_LAST = 9'(LDAC_WIDTH - 1);
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_LDAC} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;
`endif

   state_t      state_q, state_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [14:0] shreg_q, shreg_d;
   logic        pend_full_q, pend_full_d;
   logic [11:0] pend_data_q, pend_data_d;
   logic [7:0]  ovf_q, ovf_d;
   logic        sclk_q, sclk_d;
   logic        mosi_q, mosi_d;
   logic        cs_n_q, cs_n_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        ldac_n_q, ldac_n_d;
   logic        consume;
   logic [15:0] word;

   assign word    = {1'b0, BUF_BIT, GAIN_N_BIT, 1'b1, pend_data_q};
   assign consume = (state_q == S_IDLE) && pend_full_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      cs_n_d    = cs_n_q;
      done_d    = 1'b0;
      ldac_n_d  = ldac_n_q;
      case (state_q)
         S_IDLE: begin
            if (pend_full_q) begin
               shreg_d = word[14:0];
               mosi_d  = word[15];
               cs_n_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            cnt_d = cnt_q + 9'd1;
            if (cnt_q == HALF_LAST) begin
               cnt_d     = '0;
               bit_cnt_d = '0;
               sclk_d    = 1'b1;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            cnt_d = cnt_q + 9'd1;
            if (cnt_q == HALF_LAST) begin
               sclk_d = 1'b0;
               // bit0 stays on the line through HOLD
               if (bit_cnt_q != 4'd15) begin
                  mosi_d  = shreg_q[14];
                  shreg_d = {shreg_q[13:0], 1'b0};
               end
            end
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (bit_cnt_q == 4'd15) begin
                  state_d = S_HOLD;
               end else begin
                  sclk_d    = 1'b1;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
         S_HOLD: begin
            cnt_d = cnt_q + 9'd1;
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               cs_n_d  = 1'b1;
               done_d  = 1'b1;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            cnt_d = cnt_q + 9'd1;
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
`ifdef DAC_SPI_TX_LDAC_EN
               ldac_n_d = 1'b0;
               state_d  = S_LDAC;
`else
               state_d  = S_IDLE;
`endif
            end
         end
`ifdef DAC_SPI_TX_LDAC_EN
         S_LDAC: begin
            cnt_d = cnt_q + 9'd1;
            if (cnt_q == LDAC_LAST) begin
               cnt_d    = '0;
               ldac_n_d = 1'b1;
               state_d  = S_IDLE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Latest-wins buffer: a write in the consume cycle refills it without loss.
   always_comb begin
      pend_full_d = pend_full_q;
      pend_data_d = pend_data_q;
      ovf_d       = ovf_q;
      if (sample_valid) begin
         pend_full_d = 1'b1;
         pend_data_d = sample_in;
         if (pend_full_q && !consume && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
      end else if (consume) begin
         pend_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         pend_full_q <= 1'b0;
         pend_data_q <= '0;
         ovf_q       <= '0;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         cs_n_q      <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ldac_n_q    <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         pend_full_q <= pend_full_d;
         pend_data_q <= pend_data_d;
         ovf_q       <= ovf_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         cs_n_q      <= cs_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         ldac_n_q    <= ldac_n_d;
      end
   end

   assign dac_sclk      = sclk_q;
   assign dac_mosi      = mosi_q;
   assign dac_cs_n      = cs_n_q;
   assign busy          = busy_q;
   assign frame_done    = done_q;
   assign overrun_count = ovf_q;

`ifdef DAC_SPI_TX_LDAC_EN
   assign dac_ldac_n = ldac_n_q;
`else
   // Without LDAC the DAC updates on the CS rise, so the pin is held low.
   assign dac_ldac_n = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Self-checking bench for dac_spi_tx: directed test-plan steps plus random strobes,
// checked against a busy-timer / latest-wins buffer model and a SPI pin decoder.
module tb_dac_spi_tx;
   localparam int H  = 4;
   localparam int G  = 4;
`ifdef DAC_SPI_TX_LDAC_EN
   localparam int LW = 2;
`else
   localparam int LW = 0;
`endif
   localparam int T = 34 * H + G + LW;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] sample_in = '0;
   logic        sample_valid = 1'b0;
   logic        dac_sclk, dac_mosi, dac_cs_n, dac_ldac_n, busy, frame_done;
   logic [7:0]  overrun_count;

   dac_spi_tx dut (
      .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
      .dac_sclk(dac_sclk), .dac_mosi(dac_mosi), .dac_cs_n(dac_cs_n),
      .dac_ldac_n(dac_ldac_n), .busy(busy), .frame_done(frame_done),
      .overrun_count(overrun_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Model: a frame occupies T busy cycles after the idle cycle that consumes the buffer.
   int          m_timer = 0;
   bit          m_pend = 0;
   logic [11:0] m_data = '0;
   int          m_ovf = 0;
   bit          m_rst = 1;
   bit          m_cons;
   logic [15:0] exp_q[$];

   always @(posedge clk) begin
      m_rst = rst;
      if (rst) begin
         m_timer = 0; m_pend = 0; m_ovf = 0;
         exp_q.delete();
      end else begin
         m_cons = (m_timer == 0) && m_pend;
         if (m_cons) begin
            exp_q.push_back({4'b0011, m_data});
            m_timer = T;
         end else if (m_timer > 0) begin
            m_timer--;
         end
         if (sample_valid && m_pend && !m_cons && m_ovf < 255) m_ovf++;
         if (sample_valid) begin
            m_pend = 1; m_data = sample_in;
         end else if (m_cons) begin
            m_pend = 0;
         end
      end
   end

   // Pin decoder and per-cycle comparisons
   bit          prev_sclk = 0, prev_cs = 1;
   int          low_cnt = 0, rises = 0, n_frames = 0, fd_count = 0;
   logic [15:0] word = '0;
   logic [15:0] words[$];

   always @(negedge clk) begin
      if (m_rst) begin
         low_cnt = 0; rises = 0; word = '0;
      end else begin
         chk("busy", busy, m_timer != 0);
         chk("cs_n", dac_cs_n, !(m_timer > G + LW));
         chk("ldac_n", dac_ldac_n, (LW == 0) ? 1'b0 : !(m_timer >= 1 && m_timer <= LW));
         chk("overrun", overrun_count, m_ovf);
         chk("sclk_cs_high", dac_sclk && dac_cs_n, 1'b0);
         if (!dac_cs_n) low_cnt++;
         if (dac_sclk && !prev_sclk) begin
            word = {word[14:0], dac_mosi};
            rises++;
         end
         if (frame_done) fd_count++;
         if (dac_cs_n && !prev_cs) begin
            chk("frame_done_at_cs_rise", frame_done, 1'b1);
            chk("cs_low_cycles", low_cnt, 34 * H);
            chk("sclk_rises", rises, 16);
            chk("frame_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) chk("frame_word", word, exp_q.pop_front());
            words.push_back(word);
            n_frames++;
            low_cnt = 0; rises = 0;
         end else begin
            chk("frame_done_idle", frame_done, 1'b0);
         end
      end
      prev_sclk = dac_sclk;
      prev_cs   = dac_cs_n;
   end

   task automatic drive(input bit v, input logic [11:0] d);
      @(posedge clk); #2;
      sample_valid = v;
      sample_in    = d;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 12'h000);
   endtask

   task automatic wait_frames(input int target, input int budget);
      int i = 0;
      while (n_frames < target && i < budget) begin
         drive(1'b0, 12'h000);
         i++;
      end
      chk("frame_wait_timeout", n_frames >= target, 1'b1);
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   int fd0, nf, i;
   logic [11:0] rd;

   initial begin
      // Reset state
      idle(3);
      settle();
      chk("rst_cs_n", dac_cs_n, 1'b1);
      chk("rst_sclk", dac_sclk, 1'b0);
      chk("rst_mosi", dac_mosi, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_overrun", overrun_count, 8'd0);
      chk("rst_ldac_n", dac_ldac_n, (LW == 0) ? 1'b0 : 1'b1);
      @(posedge clk); #2 rst = 1'b0;
      idle(4);

      // Single frame, CS falls two edges after the strobe
      fd0 = fd_count;
      drive(1'b1, 12'hA5C);
      drive(1'b0, 12'h000);
      settle();
      chk("cs_not_yet", dac_cs_n, 1'b1);
      drive(1'b0, 12'h000);
      settle();
      chk("cs_latency", dac_cs_n, 1'b0);
      wait_frames(1, 400);
      chk("frame_a5c", words[0], 16'h3A5C);
      idle(G + LW + 4);
      chk("frame_done_count_1", fd_count - fd0, 1);
      chk("overrun_1", overrun_count, 8'd0);

      // Three strobes 40 cycles apart: middle one lost
      fd0 = fd_count;
      nf  = n_frames;
      drive(1'b1, 12'h001); idle(39);
      drive(1'b1, 12'h002); idle(39);
      drive(1'b1, 12'h003);
      wait_frames(nf + 2, 800);
      idle(G + LW + 40);
      chk("frame_001", words[nf], 16'h3001);
      chk("frame_003", words[nf + 1], 16'h3003);
      chk("overrun_2", overrun_count, 8'd1);
      chk("frame_done_count_2", fd_count - fd0, 2);

      // Paced ramp, one frame per strobe, interval shortened to keep the run short
      nf = n_frames;
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 12'(k * 512));
         idle(199);
         settle();
         chk("ramp_busy_between", busy, 1'b0);
      end
      chk("ramp_frames", n_frames - nf, 8);
      for (int k = 0; k < 8; k++) chk("ramp_word", words[nf + k], 16'h3000 | 16'(k * 512));
      chk("ramp_overrun", overrun_count, 8'd1);

      // Reset for one cycle during SHIFT bit 7
      drive(1'b1, 12'h123);
      drive(1'b0, 12'h000);
      i = 0;
      while (rises < 9 && i < 400) begin drive(1'b0, 12'h000); i++; end
      chk("reach_bit7_timeout", rises >= 9, 1'b1);
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
      settle();
      chk("midrst_cs_n", dac_cs_n, 1'b1);
      chk("midrst_sclk", dac_sclk, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_overrun", overrun_count, 8'd0);
      nf = n_frames;
      drive(1'b1, 12'hFFF);
      wait_frames(nf + 1, 400);
      chk("frame_fff", words[nf], 16'h3FFF);
      idle(G + LW + 4);

      // Continuous strobes saturate the overrun counter
      for (int k = 0; k < 300; k++) begin
         rd = 12'($urandom);
         drive(1'b1, rd);
      end
      drive(1'b0, 12'h000);
      settle();
      chk("ovf_saturated", overrun_count, 8'd255);
      idle(20);
      drive(1'b1, 12'h5A5);
      idle(2);
      settle();
      chk("ovf_hold", overrun_count, 8'd255);
      idle(2 * T + 10);

      // Random sparse and bursty strobes
      for (int k = 0; k < 4000; k++) begin
         rd = 12'($urandom);
         drive($urandom_range(0, 59) == 0, rd);
      end
      idle(2 * T + 10);
      settle();
      chk("final_idle", busy, 1'b0);
      chk("model_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=%0d expected=finish", checks);
      $fatal(1, "timeout");
   end
endmodule
